// File: rtl/icache_controller.sv
// ---------------------------------------------------------------------------
// icache_controller
//   Direct-mapped instruction cache sitting between the CPU fetch stage and
//   instruction_memory. Hits return the selected word combinationally with no
//   stall. A miss stalls the CPU, fetches a 16-byte block from memory, installs
//   it, and then the hit is served from the cache. Saturating hit/miss counters
//   are kept for performance runs.
//
// Ports
//   i_clock         system clock, all state changes on posedge
//   i_reset_n       asynchronous active-low reset
//   i_read          CPU fetch request
//   i_pc_address    byte address: tag=[9:7], index=[6:4], word=[3:2]
//   o_instruction   fetched instruction (holds last served word otherwise)
//   o_busywait      CPU stall
//   o_mem_read      block read request to instruction_memory
//   o_mem_address   block address {tag,index} to instruction_memory
//   i_mem_readinst  returned 128-bit block, word w at [32w+31:32w]
//   i_mem_busywait  instruction_memory busy
//   o_hit_count     saturating count of served fetches
//   o_miss_count    saturating count of misses
// ---------------------------------------------------------------------------
module icache_controller #(
  parameter int NUM_SETS  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_read,
  input  logic [9:0]           i_pc_address,
  output logic [31:0]          o_instruction,
  output logic                 o_busywait,
  output logic                 o_mem_read,
  output logic [5:0]           o_mem_address,
  input  logic [127:0]         i_mem_readinst,
  input  logic                 i_mem_busywait,
  output logic [CNT_WIDTH-1:0] o_hit_count,
  output logic [CNT_WIDTH-1:0] o_miss_count
);

  localparam int INDEX_BITS = $clog2(NUM_SETS);
  localparam int TAG_BITS   = 6 - INDEX_BITS;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Cache storage. Only the valid bits need a reset; tag/data are qualified by them.
  logic [NUM_SETS-1:0] r_valid;
  logic [TAG_BITS-1:0] r_tag  [NUM_SETS];
  logic [127:0]        r_data [NUM_SETS];

  logic [5:0]           r_miss_addr;
  logic [31:0]          r_instr;
  logic [CNT_WIDTH-1:0] r_hit_count;
  logic [CNT_WIDTH-1:0] r_miss_count;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [1:0]            w_word_sel;
  logic                  w_hit;
  logic [127:0]          w_line;
  logic [31:0]           w_words [4];
  logic [31:0]           w_word;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_serve;
  logic                  w_miss;
  logic                  w_fill;
  logic                  w_busy;
  logic                  w_unused;

  assign w_tag      = i_pc_address[9 -: TAG_BITS];
  assign w_index    = i_pc_address[4 +: INDEX_BITS];
  assign w_word_sel = i_pc_address[3:2];
  // Byte offset within the word is irrelevant for word-aligned fetches.
  assign w_unused   = &{1'b0, i_pc_address[1:0]};

  assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // Word select out of the indexed line.
  assign w_line = r_data[w_index];
  for (genvar gi = 0; gi < 4; gi++) begin : g_word
    assign w_words[gi] = w_line[32*gi +: 32];
  end
  assign w_word = w_words[w_word_sel];

  // Refill always targets the line latched at miss time, not the live PC.
  assign w_fill_index = r_miss_addr[INDEX_BITS-1:0];
  assign w_fill_tag   = r_miss_addr[5 -: TAG_BITS];

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and control
  always_comb begin
    w_state_next  = r_state;
    o_mem_read    = 1'b0;
    o_mem_address = '0;
    w_busy        = 1'b0;
    w_serve       = 1'b0;
    w_miss        = 1'b0;
    w_fill        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_read) begin
          if (w_hit) begin
            w_serve = 1'b1;
          end else begin
            w_busy       = 1'b1;
            w_miss       = 1'b1;
            w_state_next = S_MEM_READ;
          end
        end
      end
      S_MEM_READ: begin
        o_mem_read    = 1'b1;
        o_mem_address = r_miss_addr;
        w_busy        = 1'b1;
        // Entered on a posedge, so the earliest exit already leaves one full cycle here.
        if (!i_mem_busywait) begin
          w_state_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_busy       = 1'b1;
        w_fill       = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Stall must read low while reset is held even if a fetch is pending.
  assign o_busywait    = w_busy & i_reset_n;
  assign o_instruction = w_serve ? w_word : r_instr;
  assign o_hit_count   = r_hit_count;
  assign o_miss_count  = r_miss_count;

  // Control-side registers: valid bits, miss address, held instruction, counters.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_valid      <= '0;
      r_miss_addr  <= '0;
      r_instr      <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_miss) begin
        r_miss_addr <= {w_tag, w_index};
        if (r_miss_count != CNT_MAX) begin
          r_miss_count <= r_miss_count + CNT_ONE;
        end
      end
      if (w_serve) begin
        r_instr <= w_word;
        if (r_hit_count != CNT_MAX) begin
          r_hit_count <= r_hit_count + CNT_ONE;
        end
      end
      if (w_fill) begin
        r_valid[w_fill_index] <= 1'b1;
      end
    end
  end

  // Tag/data arrays. An abandoned refill never reaches UPDATE, so nothing is written.
  always_ff @(posedge i_clock) begin
    if (w_fill) begin
      r_tag[w_fill_index]  <= w_fill_tag;
      r_data[w_fill_index] <= i_mem_readinst;
    end
  end

endmodule
